uart_link_matrix: RTL and testbench

//  Parametrised N-channel serial interconnect for the UART environment; generalises the fixed 2-instance back-to-back wiring.

---
 rtl/uart_link_pkg.sv | 23 ++
 rtl/uart_link_idle_det.sv | 27 ++
 rtl/uart_link_matrix.sv | 151 +++++++++++++++
 tb/tb_uart_link_matrix.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_link_pkg.sv
// Shared definitions for the UART link matrix: register map, route encoding
// and the per-channel route FSM states.
package uart_link_pkg;

    localparam logic [5:0]  ROUTE_PAGE = 6'h00;
    localparam logic [5:0]  FCNT_PAGE  = 6'h02;
    localparam logic [11:0] ADDR_PEND  = 12'h040;

    typedef enum logic {
        ACTIVE = 1'b0,
        PEND   = 1'b1
    } link_state_e;

    function automatic int sel_w(input int n);
        return $clog2(n + 1);
    endfunction

    // The code one past the last channel means "disconnected".
    function automatic int route_disc(input int n);
        return n;
    endfunction

endpackage

// File: rtl/uart_link_idle_det.sv
// Saturating run-length counter of consecutive high samples on one serial line;
// the line is idle once the count reaches IDLE_CYC.
module uart_link_idle_det #(
    parameter int IDLE_CYC = 16
) (
    input  logic pclk,
    input  logic preset,
    input  logic line,
    output logic idle
);
    localparam int CW = $clog2(IDLE_CYC + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge pclk) begin
        if (preset) begin
            cnt <= '0;
        end else if (!line) begin
            cnt <= '0;
        end else if (cnt != CW'(IDLE_CYC)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign idle = (cnt == CW'(IDLE_CYC));

endmodule

// File: rtl/uart_link_matrix.sv
// N-channel UART crossbar with frame-safe route switching, per-output frame
// counters and an APB register interface.
module uart_link_matrix
    import uart_link_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int IDLE_CYC = 16,
    parameter int CNT_W    = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [11:0]       paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic [NUM_CH-1:0] uart_tx,
    output logic [NUM_CH-1:0] uart_rx,
    output logic [NUM_CH-1:0] pend
);
    localparam int SEL_W = sel_w(NUM_CH);
    localparam logic [SEL_W-1:0] DISC = SEL_W'(route_disc(NUM_CH));

    logic [SEL_W-1:0] route_q [NUM_CH];
    logic [SEL_W-1:0] route_d [NUM_CH];
    logic [SEL_W-1:0] nxt_q   [NUM_CH];
    logic [SEL_W-1:0] nxt_d   [NUM_CH];
    link_state_e      state_q [NUM_CH];
    link_state_e      state_d [NUM_CH];
    logic [CNT_W-1:0] fcnt_q  [NUM_CH];

    logic [NUM_CH-1:0] idle;
    logic [NUM_CH:0]   idle_ext;
    logic [NUM_CH:0]   tx_ext;
    logic [NUM_CH-1:0] rx_prev;
    logic [NUM_CH-1:0] wr_route;
    logic [NUM_CH-1:0] wr_fcnt;
    logic              access;
    logic              is_route;
    logic              is_fcnt;
    logic              is_pend;
    logic              idx_ok;
    logic              wdata_ok;
    logic              err;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_idle
        uart_link_idle_det #(.IDLE_CYC(IDLE_CYC)) u_det (
            .pclk  (pclk),
            .preset(preset),
            .line  (uart_tx[g]),
            .idle  (idle[g])
        );
    end

    // Extra top entry models the DISC source: constant high and always idle.
    assign idle_ext = {1'b1, idle};
    assign tx_ext   = {1'b1, uart_tx};
    assign pready   = 1'b1;

    always_comb begin
        access   = psel & penable;
        is_route = (paddr[11:6] == ROUTE_PAGE) && (paddr[1:0] == 2'b00);
        is_fcnt  = (paddr[11:6] == FCNT_PAGE) && (paddr[1:0] == 2'b00);
        is_pend  = (paddr == ADDR_PEND);
        idx_ok   = 32'(paddr[5:2]) < NUM_CH;
        wdata_ok = pwdata <= 32'(NUM_CH);
        err      = access & (!(is_route | is_fcnt | is_pend)
                          | ((is_route | is_fcnt) & !idx_ok)
                          | (is_route & pwrite & !wdata_ok)
                          | (is_pend & pwrite));
        pslverr  = err;
        prdata   = '0;
        wr_route = '0;
        wr_fcnt  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pend[i] = (state_q[i] == PEND);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (access && !err && (paddr[5:2] == 4'(i))) begin
                wr_route[i] = pwrite & is_route;
                wr_fcnt[i]  = pwrite & is_fcnt;
                if (!pwrite && is_route) prdata = 32'(route_q[i]);
                if (!pwrite && is_fcnt)  prdata = 32'(fcnt_q[i]);
            end
        end
        if (access && !err && !pwrite && is_pend) begin
            prdata = 32'(pend);
        end
    end

    // A route write always wins over a commit landing in the same cycle.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            route_d[i] = route_q[i];
            nxt_d[i]   = nxt_q[i];
            if (wr_route[i]) begin
                if (pwdata[SEL_W-1:0] == route_q[i]) begin
                    state_d[i] = ACTIVE;
                end else begin
                    state_d[i] = PEND;
                    nxt_d[i]   = pwdata[SEL_W-1:0];
                end
            end else if (state_q[i] == PEND && idle_ext[route_q[i]] && idle_ext[nxt_q[i]]) begin
                state_d[i] = ACTIVE;
                route_d[i] = nxt_q[i];
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                route_q[i] <= SEL_W'(i ^ 1);
                nxt_q[i]   <= DISC;
                state_q[i] <= ACTIVE;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                route_q[i] <= route_d[i];
                nxt_q[i]   <= nxt_d[i];
                state_q[i] <= state_d[i];
            end
        end
    end

    // Frame counters watch the registered output, so they count what the receiver sees.
    always_ff @(posedge pclk) begin
        if (preset) begin
            uart_rx <= '1;
            rx_prev <= '1;
            for (int i = 0; i < NUM_CH; i++) begin
                fcnt_q[i] <= '0;
            end
        end else begin
            rx_prev <= uart_rx;
            for (int i = 0; i < NUM_CH; i++) begin
                uart_rx[i] <= tx_ext[route_q[i]];
                if (wr_fcnt[i]) begin
                    fcnt_q[i] <= '0;
                end else if (rx_prev[i] && !uart_rx[i]) begin
                    fcnt_q[i] <= fcnt_q[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_link_matrix.sv
// Directed bench for uart_link_matrix (NUM_CH=4, IDLE_CYC=16): reset state,
// frame-safe route switching, frame counting and APB error handling.
module tb_uart_link_matrix;

    logic        pclk = 1'b0;
    logic        preset;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [3:0]  uart_tx;
    logic [3:0]  uart_rx;
    logic [3:0]  pend;

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    uart_link_matrix #(.NUM_CH(4), .IDLE_CYC(16), .CNT_W(16)) dut (
        .pclk   (pclk),
        .preset (preset),
        .psel   (psel),
        .penable(penable),
        .pwrite (pwrite),
        .paddr  (paddr),
        .pwdata (pwdata),
        .prdata (prdata),
        .pready (pready),
        .pslverr(pslverr),
        .uart_tx(uart_tx),
        .uart_rx(uart_rx),
        .pend   (pend)
    );

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // One APB transfer; prdata/pslverr are sampled mid access phase.
    task automatic applyStimulus(input bit wr, input logic [11:0] addr, input logic [31:0] data,
                                 output logic [31:0] rdata, output logic err);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        tick();
        penable = 1'b1;
        #1;
        rdata = prdata;
        err   = pslverr;
        @(posedge pclk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        logic [9:0]  frame;

        preset  = 1'b1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        uart_tx = 4'b1101;

        // Reset state and crossover routing (rx0<-tx1, rx1<-tx0, rx2<-tx3, rx3<-tx2)
        repeat (2) tick();
        checkOutput("rx_in_reset", uart_rx, 4'hF);
        checkOutput("pend_in_reset", pend, 4'h0);
        checkOutput("pready", pready, 1'b1);
        preset = 1'b0;
        tick();
        checkOutput("rx_after_reset", uart_rx, 4'b1110);
        checkOutput("prdata_idle", prdata, 32'h0);
        applyStimulus(1'b0, 12'h040, 0, rd, err);
        checkOutput("pend_reg_reset", rd, 0);
        applyStimulus(1'b0, 12'h084, 0, rd, err);
        checkOutput("fcnt1_reset", rd, 0);
        applyStimulus(1'b0, 12'h08C, 0, rd, err);
        checkOutput("fcnt3_reset", rd, 0);
        // rx0 fell 1->0 when reset released, which is one counted transition
        applyStimulus(1'b0, 12'h080, 0, rd, err);
        checkOutput("fcnt0_first_fall", rd, 1);

        // Switch rx0 to tx2 while tx2 is busy; commits only after 16 high cycles
        uart_tx = 4'hF;
        repeat (20) tick();
        uart_tx[2] = 1'b0;
        applyStimulus(1'b1, 12'h000, 2, rd, err);
        checkOutput("route0_wr_err", err, 1'b0);
        checkOutput("pend_after_wr", pend, 4'b0001);
        for (int k = 0; k < 6; k++) begin
            uart_tx[2] = ~uart_tx[2];
            tick();
        end
        checkOutput("pend_while_busy", pend, 4'b0001);
        checkOutput("rx0_old_source", uart_rx[0], 1'b1);
        uart_tx[2] = 1'b1;
        repeat (16) tick();
        checkOutput("pend_before_idle", pend, 4'b0001);
        tick();
        checkOutput("pend_committed", pend, 4'b0000);
        uart_tx[2] = 1'b0;
        tick();
        checkOutput("rx0_follows_tx2", uart_rx[0], 1'b0);
        uart_tx[2] = 1'b1;
        tick();
        checkOutput("rx0_follows_tx2_hi", uart_rx[0], 1'b1);

        // Overwrite then cancel a pending change while both sources are mid-frame
        uart_tx = 4'b1001;
        tick();
        applyStimulus(1'b1, 12'h000, 3, rd, err);
        checkOutput("pend_to3", pend, 4'b0001);
        checkOutput("rx0_no_glitch_a", uart_rx[0], 1'b0);
        applyStimulus(1'b1, 12'h000, 1, rd, err);
        checkOutput("pend_overwrite", pend, 4'b0001);
        checkOutput("rx0_no_glitch_b", uart_rx[0], 1'b0);
        applyStimulus(1'b1, 12'h000, 2, rd, err);
        checkOutput("pend_cancel", pend, 4'b0000);
        checkOutput("rx0_no_glitch_c", uart_rx[0], 1'b0);
        uart_tx = 4'hF;
        repeat (20) tick();
        applyStimulus(1'b0, 12'h000, 0, rd, err);
        checkOutput("route0_kept", rd, 2);
        checkOutput("pend_stays_clear", pend, 4'b0000);

        // Three 0x55 frames on tx0 -> rx1: start + 4 data falls each = 15
        applyStimulus(1'b0, 12'h084, 0, rd, err);
        checkOutput("fcnt1_pre", rd, 0);
        frame = {1'b1, 8'h55, 1'b0};
        for (int f = 0; f < 3; f++) begin
            for (int b = 0; b < 10; b++) begin
                uart_tx[0] = frame[b];
                repeat (4) tick();
            end
        end
        repeat (4) tick();
        applyStimulus(1'b0, 12'h084, 0, rd, err);
        checkOutput("fcnt1_frames", rd, 15);
        applyStimulus(1'b1, 12'h084, 32'hDEAD, rd, err);
        checkOutput("fcnt1_clr_err", err, 1'b0);
        applyStimulus(1'b0, 12'h084, 0, rd, err);
        checkOutput("fcnt1_cleared", rd, 0);

        // Error responses leave state untouched; route 4 disconnects rx0
        applyStimulus(1'b1, 12'h000, 5, rd, err);
        checkOutput("err_route_5", err, 1'b1);
        checkOutput("pend_after_bad", pend, 4'b0000);
        applyStimulus(1'b0, 12'h000, 0, rd, err);
        checkOutput("route0_unchanged", rd, 2);
        applyStimulus(1'b0, 12'h0C0, 0, rd, err);
        checkOutput("err_unmapped", err, 1'b1);
        checkOutput("rd_unmapped_zero", rd, 0);
        applyStimulus(1'b1, 12'h040, 32'hF, rd, err);
        checkOutput("err_wr_pend", err, 1'b1);
        applyStimulus(1'b0, 12'h090, 0, rd, err);
        checkOutput("err_fcnt_idx4", err, 1'b1);
        applyStimulus(1'b1, 12'h000, 4, rd, err);
        checkOutput("route0_disc_err", err, 1'b0);
        applyStimulus(1'b0, 12'h040, 0, rd, err);
        checkOutput("pend_disc_done", rd, 0);
        applyStimulus(1'b0, 12'h000, 0, rd, err);
        checkOutput("route0_disc", rd, 4);
        uart_tx = 4'b1011;
        repeat (2) tick();
        checkOutput("rx_disc_vector", uart_rx, 4'b0111);

        // Reset while channel 2 is pending discards the pending source
        uart_tx = 4'b1110;
        tick();
        applyStimulus(1'b1, 12'h008, 0, rd, err);
        checkOutput("pend2_set", pend, 4'b0100);
        preset = 1'b1;
        tick();
        checkOutput("pend_reset_mid", pend, 4'b0000);
        checkOutput("rx_reset_mid", uart_rx, 4'hF);
        applyStimulus(1'b0, 12'h008, 0, rd, err);
        checkOutput("route2_reset", rd, 3);
        preset  = 1'b0;
        uart_tx = 4'hF;
        repeat (20) tick();
        applyStimulus(1'b0, 12'h008, 0, rd, err);
        checkOutput("route2_no_commit", rd, 3);
        checkOutput("pend_final", pend, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
